// File: rtl/sda_ser.sv
// Frame serializer for the SDAM link: buffers {addr,data} frames in a small FIFO
// and shifts each one out on sda as START, GAP, 8 addr bits, 16 data bits, STOP.
`timescale 1ns/1ps
module sda_ser #(
   parameter int FIFO_DEPTH = 4,
   parameter int STOP_LEN   = 1
) (
   input  logic        scl,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_addr,
   input  logic [15:0] in_data,
   output logic        sda,
   output logic        busy,
   output logic [3:0]  fifo_level,
   output logic [7:0]  frame_cnt
);

   localparam int              PTR_W      = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
   localparam logic [3:0]      LEVEL_FULL = 4'(FIFO_DEPTH);
   localparam logic [2:0]      STOP_LAST  = 3'(STOP_LEN - 1);

   typedef enum logic [2:0] {IDLE, START, GAP, ADDR, DATA, STOP} state_t;

   state_t           state_q, state_d;
   logic             sda_q, sda_d;
   logic             busy_q, busy_d;
   logic [23:0]      shift_q, shift_d;
   logic [4:0]       bit_cnt_q, bit_cnt_d;
   logic [2:0]       stop_cnt_q, stop_cnt_d;
   logic [7:0]       frame_cnt_q, frame_cnt_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [3:0]       level_q, level_d;
   logic [23:0]      mem_q [FIFO_DEPTH];
   logic             push;
   logic             pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   // Readiness comes from the registered level only, so a pop on the same edge never frees a slot early.
   assign in_ready = (level_q != LEVEL_FULL);
   assign push     = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      sda_d       = sda_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      stop_cnt_d  = stop_cnt_q;
      frame_cnt_d = frame_cnt_q;
      pop         = 1'b0;
      unique case (state_q)
         IDLE: begin
            sda_d = 1'b1;
            if (level_q != 4'd0) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q];
               state_d = START;
               sda_d   = 1'b0;
            end
         end
         START: begin
            state_d = GAP;
            sda_d   = 1'b1;
         end
         GAP: begin
            state_d   = ADDR;
            sda_d     = shift_q[0];
            shift_d   = {1'b0, shift_q[23:1]};
            bit_cnt_d = '0;
         end
         // shift_q holds {data,addr}, so LSB-first shifting sends addr[0..7] then data[0..15].
         ADDR: begin
            sda_d     = shift_q[0];
            shift_d   = {1'b0, shift_q[23:1]};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) state_d = DATA;
         end
         DATA: begin
            sda_d     = shift_q[0];
            shift_d   = {1'b0, shift_q[23:1]};
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd23) begin
               state_d    = STOP;
               sda_d      = 1'b1;
               stop_cnt_d = '0;
            end
         end
         STOP: begin
            sda_d = 1'b1;
            if (stop_cnt_q == STOP_LAST) begin
               state_d     = IDLE;
               frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
               stop_cnt_d = stop_cnt_q + 3'd1;
            end
         end
         default: begin
            state_d = IDLE;
            sda_d   = 1'b1;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   always_comb begin
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      unique case ({push, pop})
         2'b10:   level_d = level_q + 4'd1;
         2'b01:   level_d = level_q - 4'd1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge scl) begin
      if (reset) begin
         state_q     <= IDLE;
         sda_q       <= 1'b1;
         busy_q      <= 1'b0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         stop_cnt_q  <= '0;
         frame_cnt_q <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
      end else begin
         state_q     <= state_d;
         sda_q       <= sda_d;
         busy_q      <= busy_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         stop_cnt_q  <= stop_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
      end
   end

   always_ff @(posedge scl) begin
      if (push && !reset) mem_q[wr_ptr_q] <= {in_data, in_addr};
   end

   assign sda        = sda_q;
   assign busy       = busy_q;
   assign fifo_level = level_q;
   assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_sda_ser.sv
// Directed bench for sda_ser: vector table of single frames plus multi-cycle
// sequences, with a serial decoder checking every transmitted frame in order.
`timescale 1ns/1ps
module tb_sda_ser;

   localparam int MAIN_STOP = 1;

   logic        scl = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [7:0]  in_addr;
   logic [15:0] in_data;
   logic        sda, busy;
   logic [3:0]  fifo_level;
   logic [7:0]  frame_cnt;

   logic        in_valid3, in_ready3;
   logic [7:0]  in_addr3;
   logic [15:0] in_data3;
   logic        sda3, busy3;
   logic [3:0]  fifo_level3;
   logic [7:0]  frame_cnt3;

   int n_tests = 0;
   int n_fail  = 0;

   logic [23:0] sb[$];
   int          dphase = 0, dcnt = 0, dstop = 0, dec_frames = 0;
   logic [23:0] dbits;

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] data;
      logic [26:0] exp_sda;
   } vec_t;
   vec_t vecs[6];

   logic [26:0] got_sda, got_busy;
   logic [28:0] got3;
   logic [3:0]  lvl0;
   logic        ready_ok, busy_last3, timeout;
   int          exp_frames, dec_base, sent, nb;

   always #5 scl = ~scl;

   sda_ser #(.FIFO_DEPTH(4), .STOP_LEN(MAIN_STOP)) u_dut (
      .scl(scl), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .sda(sda), .busy(busy),
      .fifo_level(fifo_level), .frame_cnt(frame_cnt));

   sda_ser #(.FIFO_DEPTH(4), .STOP_LEN(3)) u_dut3 (
      .scl(scl), .reset(reset), .in_valid(in_valid3), .in_ready(in_ready3),
      .in_addr(in_addr3), .in_data(in_data3), .sda(sda3), .busy(busy3),
      .fifo_level(fifo_level3), .frame_cnt(frame_cnt3));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Downstream deserializer model: START(0), GAP(1), 24 bits LSB first, stop ones.
   always @(negedge scl) begin
      if (reset === 1'b1) begin
         dphase = 0;
      end else begin
         case (dphase)
            0: if (sda === 1'b0) dphase = 1;
            1: begin
               check("dec_gap", 32'(sda), 32'd1);
               dphase = 2;
               dcnt   = 0;
            end
            2: begin
               dbits[dcnt] = sda;
               dcnt++;
               if (dcnt == 24) begin
                  dphase = 3;
                  dstop  = 0;
               end
            end
            default: begin
               check("dec_stop", 32'(sda), 32'd1);
               dstop++;
               if (dstop == MAIN_STOP) begin
                  dec_frames++;
                  if (sb.size() == 0) begin
                     n_tests++;
                     n_fail++;
                     $display("FAIL dec_unexpected: got frame 0x%0h, expected no frame", dbits);
                  end else begin
                     check("dec_frame", 32'(dbits), 32'(sb.pop_front()));
                  end
                  dphase = 0;
               end
            end
         endcase
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{8'hA5, 16'h3C0F, 27'b0_1_1010_0101_1111_0000_0011_1100_1};
      vecs[1] = '{8'h00, 16'h0000, 27'b0_1_0000_0000_0000_0000_0000_0000_1};
      vecs[2] = '{8'hFF, 16'hFFFF, 27'b0_1_1111_1111_1111_1111_1111_1111_1};
      vecs[3] = '{8'h01, 16'h8000, 27'b0_1_1000_0000_0000_0000_0000_0001_1};
      vecs[4] = '{8'h80, 16'h0001, 27'b0_1_0000_0001_1000_0000_0000_0000_1};
      vecs[5] = '{8'h3C, 16'hA55A, 27'b0_1_0011_1100_0101_1010_1010_0101_1};

      reset = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
      in_valid3 = 1'b0; in_addr3 = '0; in_data3 = '0;
      repeat (3) @(negedge scl);
      check("rst_sda", 32'(sda), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd1);
      reset = 1'b0;
      exp_frames = 0;

      // STOP_LEN=3 instance: 29-cycle frame with three trailing ones.
      in_valid3 = 1'b1; in_addr3 = 8'hA5; in_data3 = 16'h3C0F;
      @(negedge scl);
      in_valid3 = 1'b0;
      for (int i = 0; i < 29; i++) begin
         @(negedge scl);
         got3[28-i] = sda3;
         if (i == 28) busy_last3 = busy3;
      end
      check("stop3_sda", 32'(got3), 32'(29'b0_1_1010_0101_1111_0000_0011_1100_111));
      check("stop3_busy_in_stop", 32'(busy_last3), 32'd1);
      @(negedge scl);
      check("stop3_idle_busy", 32'(busy3), 32'd0);
      check("stop3_frame_cnt", 32'(frame_cnt3), 32'd1);

      // Table: single frames into an idle, empty block.
      for (int v = 0; v < 6; v++) begin
         in_valid = 1'b1; in_addr = vecs[v].addr; in_data = vecs[v].data;
         sb.push_back({vecs[v].data, vecs[v].addr});
         @(negedge scl);
         in_valid = 1'b0;
         check("vec_accept_level", 32'(fifo_level), 32'd1);
         check("vec_accept_sda", 32'(sda), 32'd1);
         for (int i = 0; i < 27; i++) begin
            @(negedge scl);
            got_sda[26-i]  = sda;
            got_busy[26-i] = busy;
            if (i == 0) lvl0 = fifo_level;
         end
         check("vec_sda", 32'(got_sda), 32'(vecs[v].exp_sda));
         check("vec_busy", 32'(got_busy), 32'h07FF_FFFF);
         check("vec_pop_level", 32'(lvl0), 32'd0);
         @(negedge scl);
         exp_frames++;
         check("vec_idle_sda", 32'(sda), 32'd1);
         check("vec_idle_busy", 32'(busy), 32'd0);
         check("vec_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
      end

      // Back-to-back fill while a lead frame is on the wire, then full pop with a rejected push.
      in_valid = 1'b1; in_addr = 8'h11; in_data = 16'h2233;
      sb.push_back({16'h2233, 8'h11});
      @(negedge scl);
      in_valid = 1'b0;
      @(negedge scl);
      check("b2b_lead_busy", 32'(busy), 32'd1);
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_addr = 8'(8'h40 + k); in_data = 16'(16'h1000 * (k + 1) + k);
         sb.push_back({in_data, in_addr});
         check("b2b_ready", 32'(in_ready), 32'd1);
         @(negedge scl);
      end
      check("b2b_full_ready", 32'(in_ready), 32'd0);
      check("b2b_full_level", 32'(fifo_level), 32'd4);
      in_addr = 8'hDE; in_data = 16'hDEAD;
      ready_ok = 1'b1;
      repeat (23) begin
         @(negedge scl);
         if (in_ready !== 1'b0) ready_ok = 1'b0;
      end
      check("b2b_ready_held_low", 32'(ready_ok), 32'd1);
      check("b2b_idle_busy", 32'(busy), 32'd0);
      check("b2b_idle_level", 32'(fifo_level), 32'd4);
      @(negedge scl);
      in_valid = 1'b0;
      check("full_pop_level", 32'(fifo_level), 32'd3);
      check("full_pop_ready", 32'(in_ready), 32'd1);
      check("full_pop_busy", 32'(busy), 32'd1);
      repeat (110) @(negedge scl);
      check("b2b_cnt_before_last", 32'(frame_cnt), 32'(exp_frames + 4));
      check("b2b_busy_last_stop", 32'(busy), 32'd1);
      @(negedge scl);
      exp_frames += 5;
      check("b2b_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
      check("b2b_done_busy", 32'(busy), 32'd0);
      check("b2b_done_level", 32'(fifo_level), 32'd0);

      // Reset in DATA bit 5 with two frames queued; reset beats a concurrent push.
      in_valid = 1'b1; in_addr = 8'h77; in_data = 16'h0020;
      sb.push_back({16'h0020, 8'h77});
      @(negedge scl);
      in_addr = 8'h88; in_data = 16'h1111;
      sb.push_back({16'h1111, 8'h88});
      @(negedge scl);
      check("pushpop_level", 32'(fifo_level), 32'd1);
      in_addr = 8'h99; in_data = 16'h2222;
      sb.push_back({16'h2222, 8'h99});
      @(negedge scl);
      in_valid = 1'b0;
      check("rstmid_queued_level", 32'(fifo_level), 32'd2);
      repeat (13) @(negedge scl);
      check("rstmid_data_bit4", 32'(sda), 32'd0);
      @(negedge scl);
      check("rstmid_data_bit5", 32'(sda), 32'd1);
      reset = 1'b1; in_valid = 1'b1; in_addr = 8'hEE; in_data = 16'hBEEF;
      dec_base = dec_frames;
      sb.delete();
      @(negedge scl);
      check("rstmid_sda", 32'(sda), 32'd1);
      check("rstmid_busy", 32'(busy), 32'd0);
      check("rstmid_level", 32'(fifo_level), 32'd0);
      check("rstmid_frame_cnt", 32'(frame_cnt), 32'd0);
      check("rstmid_ready", 32'(in_ready), 32'd1);
      reset = 1'b0; in_valid = 1'b0;
      repeat (40) @(negedge scl);
      check("rstmid_no_frame", 32'(dec_frames - dec_base), 32'd0);
      check("rstmid_stays_idle", 32'(busy), 32'd0);

      // 257 frames in batches: counter wraps to 1, pointers wrap many times.
      exp_frames = 0;
      dec_base   = dec_frames;
      sent       = 0;
      while (sent < 257) begin
         nb = (257 - sent >= 4) ? 4 : 257 - sent;
         for (int k = 0; k < nb; k++) begin
            in_valid = 1'b1;
            in_addr  = 8'(sent) ^ 8'h5A;
            in_data  = 16'(sent * 40503);
            sb.push_back({in_data, in_addr});
            if (k == nb - 1) check("wrap_ready", 32'(in_ready), 32'd1);
            @(negedge scl);
            sent++;
         end
         in_valid = 1'b0;
         exp_frames += nb;
         timeout = 1'b1;
         for (int c = 0; c < 300; c++) begin
            @(negedge scl);
            if (frame_cnt == 8'(exp_frames) && busy == 1'b0 && fifo_level == 4'd0) begin
               timeout = 1'b0;
               break;
            end
         end
         check("wrap_wait_timeout", 32'(timeout), 32'd0);
      end
      check("wrap_frame_cnt", 32'(frame_cnt), 32'd1);
      check("wrap_dec_count", 32'(dec_frames - dec_base), 32'd257);
      check("wrap_sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sda_ser.md
SDA_SER -- requirements
Module: sda_ser

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of frame entries buffered; legal values are 2, 4 or 8.
REQ-002 SHALL have parameter STOP_LEN, default 1, meaning the high sda cycles after the last data bit; legal range is 1..7.
REQ-003 SHALL have port scl, input, 1 bit: the one clock; all logic updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the upstream offers a frame.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a frame.
REQ-007 SHALL have port in_addr, input, 8 bits: frame address.
REQ-008 SHALL have port in_data, input, 16 bits: frame data.
REQ-009 SHALL have port sda, output, 1 bit: serial stream to the SDAM deserializer; registered.
REQ-010 SHALL have port busy, output, 1 bit: a frame is being transmitted.
REQ-011 SHALL have port fifo_level, output, 4 bits: the number of buffered frames.
REQ-012 SHALL have port frame_cnt, output, 8 bits: count of completed frames.

Function
REQ-013 SHALL accept a frame on the rising edge where in_valid=1 and in_ready=1; in_ready SHALL equal (fifo_level != FIFO_DEPTH) and SHALL NOT depend on a same-cycle pop.
REQ-014 SHALL store {in_addr,in_data} in a circular FIFO; read and write pointers wrap from FIFO_DEPTH-1 to 0.
REQ-015 SHALL use FSM states IDLE, START, GAP, ADDR, DATA, STOP.
REQ-016 In IDLE with fifo_level>0, SHALL pop the head entry into a shift register and go to START on the same edge; otherwise SHALL stay in IDLE.
REQ-017 START SHALL last 1 cycle with sda=0, then go to GAP.
REQ-018 GAP SHALL last 1 cycle with sda=1, covering the downstream START slot, then go to ADDR.
REQ-019 ADDR SHALL last 8 cycles, driving in_addr bit 0 first through bit 7, then go to DATA.
REQ-020 DATA SHALL last 16 cycles, driving in_data bit 0 first through bit 15, then go to STOP.
REQ-021 STOP SHALL last STOP_LEN cycles with sda=1, then go to IDLE; frame_cnt SHALL increment on the STOP-to-IDLE edge and wrap from 255 to 0.
REQ-022 Because sda is registered, the sda value for a state SHALL appear in the cycle that state is current; sda SHALL be 1 in IDLE.
REQ-023 Frame length SHALL be 26+STOP_LEN cycles; consecutive frames SHALL be separated by exactly one IDLE cycle (sda=1) when the FIFO is non-empty.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 A simultaneous push and pop SHALL leave fifo_level unchanged.
REQ-026 A push to an empty FIFO while IDLE SHALL be popped on the following edge, giving 2 cycles from the accept edge to sda=0; there is no bypass.
REQ-027 in_addr and in_data SHALL be ignored when in_valid=0 or in_ready=0.
REQ-028 A bit counter of 5 bits SHALL index the ADDR and DATA phases; a separate 3-bit counter SHALL time STOP.

Reset
REQ-029 On a rising edge with reset=1, the block SHALL set: state IDLE, sda=1, busy=0, fifo_level=0, both pointers 0, frame_cnt=0; in_ready becomes 1 as a result.
REQ-030 Reset mid-frame SHALL abort the frame and discard all buffered entries; sda=1 from the next cycle with no partial bits.
REQ-031 Reset SHALL take priority over a push or pop on the same edge.

Verification
REQ-032 Single frame: push addr=8'hA5, data=16'h3C0F into an idle, empty block -> sda = 0, 1, 1,0,1,0,0,1,0,1, 1,1,1,1,0,0,0,0,0,0,1,1,1,1,0,0, 1. Downstream SDAM model then reports aout=8'hA5, dout=16'h3C0F, avalid=dvalid=1 for one cycle. frame_cnt=1.
REQ-033 Back-to-back: push 4 frames in consecutive cycles -> in_ready=0 after the 4th push until the first pop. All 4 frames are sent in order, with one IDLE cycle between them. frame_cnt=4.
REQ-034 Full with simultaneous pop: FIFO full in IDLE, pop edge coincides with in_valid=1 -> the push is rejected (in_ready=0). fifo_level goes 4 to 3.
REQ-035 Reset during the DATA phase (bit 5) with 2 entries queued -> next cycle sda=1, busy=0, fifo_level=0, frame_cnt=0. The downstream model reports no avalid.
REQ-036 Wrap: send 257 frames -> frame_cnt reads 1. Pointer wrap carries no data corruption; each aout/dout matches its pushed frame.
REQ-037 STOP_LEN=3: frame length is 29 cycles, with sda=1 for 3 cycles after data bit 15.
